// File: rtl/uart_rx_peri.sv
// uart_rx_peri: memory-mapped UART receiver (8N1, optional even parity).
// Over-samples uart_rxd_i, deframes bytes into an RX FIFO, and exposes
// RXDATA/STATUS/BAUD/CTRL registers on the peripheral bus.
// Optional feature: define UART_RX_PARITY_EN for even-parity checking
// (PARITY state, STATUS[4] parity_err, CTRL[2] parity_en).
module uart_rx_peri #(
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        uart_rxd_i,
   input  logic        req_i,
   input  logic        sel_i,
   input  logic        we_i,
   input  logic [3:0]  addr_i,
   input  logic [31:0] w_data_i,
   output logic [31:0] r_data_o,
   output logic        ack_o,
   output logic        irq_o
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t      state;
   logic        rxd_s1, rxd_s2, rxd_prev;
   logic        fall;
   logic [15:0] baud, div_eff, div_lat, cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shreg;
   logic        rx_en, irq_en;
   logic        push_stb, set_frame;
   logic [7:0]  push_data;
   logic        overrun, frame_err;
`ifdef UART_RX_PARITY_EN
   logic        parity_en, parity_err, set_par, par_bad;
`endif

   logic [7:0]  mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic        empty, full;

   logic        bus_hit, wr_hit, rd_hit, w1c;
   logic [1:0]  reg_sel;
   logic        do_pop, do_push, ovr_set;
   logic [31:0] status_word, ctrl_word, rd_mux;
   logic        unused_bits;

   assign unused_bits = &{1'b0, addr_i[1:0], w_data_i[31:16]};

   assign fall    = rxd_prev & ~rxd_s2;
   assign div_eff = (baud < 16'd4) ? 16'd4 : baud;

   assign bus_hit = req_i & sel_i;
   assign wr_hit  = bus_hit & we_i;
   assign rd_hit  = bus_hit & ~we_i;
   assign reg_sel = addr_i[3:2];
   assign w1c     = wr_hit & (reg_sel == 2'd1);

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
   assign do_pop  = rd_hit & (reg_sel == 2'd0) & ~empty;
   assign do_push = push_stb & (~full | do_pop);
   assign ovr_set = push_stb & full & ~do_pop;

   // Register read views and read-data mux.
   always_comb begin
      status_word    = '0;
      status_word[0] = ~empty;
      status_word[1] = full;
      status_word[2] = overrun;
      status_word[3] = frame_err;
      ctrl_word      = '0;
      ctrl_word[0]   = rx_en;
      ctrl_word[1]   = irq_en;
`ifdef UART_RX_PARITY_EN
      status_word[4] = parity_err;
      ctrl_word[2]   = parity_en;
`endif
      rd_mux = '0;
      case (reg_sel)
         2'd0:    rd_mux[7:0]  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
         2'd1:    rd_mux       = status_word;
         2'd2:    rd_mux[15:0] = baud;
         default: rd_mux       = ctrl_word;
      endcase
   end

   // Two-flop synchronizer plus one flop of edge history; idle level is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxd_s1   <= 1'b1;
         rxd_s2   <= 1'b1;
         rxd_prev <= 1'b1;
      end else begin
         rxd_s1   <= uart_rxd_i;
         rxd_s2   <= rxd_s1;
         rxd_prev <= rxd_s2;
      end
   end

   // Receive FSM: mid-bit sampling with a divider latched at frame start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         div_lat   <= DEFAULT_DIV;
         bit_idx   <= '0;
         shreg     <= '0;
         push_stb  <= 1'b0;
         push_data <= '0;
         set_frame <= 1'b0;
`ifdef UART_RX_PARITY_EN
         set_par   <= 1'b0;
         par_bad   <= 1'b0;
`endif
      end else begin
         push_stb  <= 1'b0;
         set_frame <= 1'b0;
`ifdef UART_RX_PARITY_EN
         set_par   <= 1'b0;
`endif
         if (!rx_en) begin
            state <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (fall) begin
                     state   <= S_START;
                     div_lat <= div_eff;
                     cnt     <= div_eff >> 1;
                  end
               end
               S_START: begin
                  if (cnt == 16'd0) begin
                     if (!rxd_s2) begin
                        state   <= S_DATA;
                        cnt     <= div_lat - 16'd1;
                        bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                        par_bad <= 1'b0;
`endif
                     end else begin
                        state <= S_IDLE;
                     end
                  end else begin
                     cnt <= cnt - 16'd1;
                  end
               end
               S_DATA: begin
                  if (cnt == 16'd0) begin
                     shreg <= {rxd_s2, shreg[7:1]};
                     cnt   <= div_lat - 16'd1;
                     if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state <= parity_en ? S_PARITY : S_STOP;
`else
                        state <= S_STOP;
`endif
                     end else begin
                        bit_idx <= bit_idx + 3'd1;
                     end
                  end else begin
                     cnt <= cnt - 16'd1;
                  end
               end
`ifdef UART_RX_PARITY_EN
               S_PARITY: begin
                  if (cnt == 16'd0) begin
                     if (rxd_s2 != ^shreg) begin
                        par_bad <= 1'b1;
                        set_par <= 1'b1;
                     end
                     cnt   <= div_lat - 16'd1;
                     state <= S_STOP;
                  end else begin
                     cnt <= cnt - 16'd1;
                  end
               end
`endif
               S_STOP: begin
                  if (cnt == 16'd0) begin
                     if (rxd_s2) begin
`ifdef UART_RX_PARITY_EN
                        push_stb <= ~par_bad;
`else
                        push_stb <= 1'b1;
`endif
                        push_data <= shreg;
                     end else begin
                        set_frame <= 1'b1;
                     end
                     state <= S_IDLE;
                  end else begin
                     cnt <= cnt - 16'd1;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   // FIFO pointers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // FIFO storage (contents need no reset; pointers define validity).
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   // Bus registers, sticky status flags (hardware set beats W1C), irq.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         baud       <= DEFAULT_DIV;
         rx_en      <= 1'b0;
         irq_en     <= 1'b0;
         overrun    <= 1'b0;
         frame_err  <= 1'b0;
         ack_o      <= 1'b0;
         r_data_o   <= '0;
         irq_o      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_en  <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         ack_o    <= bus_hit;
         r_data_o <= rd_hit ? rd_mux : '0;
         if (wr_hit && reg_sel == 2'd2) baud <= w_data_i[15:0];
         if (wr_hit && reg_sel == 2'd3) begin
            rx_en  <= w_data_i[0];
            irq_en <= w_data_i[1];
`ifdef UART_RX_PARITY_EN
            parity_en <= w_data_i[2];
`endif
         end
         overrun   <= ovr_set   | (overrun   & ~(w1c & w_data_i[2]));
         frame_err <= set_frame | (frame_err & ~(w1c & w_data_i[3]));
`ifdef UART_RX_PARITY_EN
         parity_err <= set_par  | (parity_err & ~(w1c & w_data_i[4]));
         irq_o <= irq_en & (~empty | overrun | frame_err | parity_err);
`else
         irq_o <= irq_en & (~empty | overrun | frame_err);
`endif
      end
   end

endmodule

// File: tb/tb_uart_rx_peri.sv
// Directed self-checking bench for uart_rx_peri at BAUD=16.
module tb_uart_rx_peri;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        uart_rxd_i;
   logic        req_i, sel_i, we_i;
   logic [3:0]  addr_i;
   logic [31:0] w_data_i;
   logic [31:0] r_data_o;
   logic        ack_o;
   logic        irq_o;

   int checks = 0;
   int errors = 0;

   logic [31:0] rd;
   logic        ak;
   logic [7:0]  v;

   uart_rx_peri #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd868)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .uart_rxd_i (uart_rxd_i),
      .req_i      (req_i),
      .sel_i      (sel_i),
      .we_i       (we_i),
      .addr_i     (addr_i),
      .w_data_i   (w_data_i),
      .r_data_o   (r_data_o),
      .ack_o      (ack_o),
      .irq_o      (irq_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // All tasks start and end #1 after a rising edge.
   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      req_i = 1'b1; sel_i = 1'b1; we_i = 1'b1; addr_i = a; w_data_i = d;
      @(posedge clk); #1;
      req_i = 1'b0; sel_i = 1'b0; we_i = 1'b0; w_data_i = '0;
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [31:0] d, output logic ackv);
      req_i = 1'b1; sel_i = 1'b1; we_i = 1'b0; addr_i = a;
      @(posedge clk); #1;
      d = r_data_o; ackv = ack_o;
      req_i = 1'b0; sel_i = 1'b0;
   endtask

   task automatic hold_bit(input logic b);
      uart_rxd_i = b;
      repeat (16) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b,
                             input logic has_par, input logic par_b);
      hold_bit(1'b0);
      for (int b = 0; b < 8; b++) hold_bit(d[b]);
      if (has_par) hold_bit(par_b);
      hold_bit(stop_b);
      uart_rxd_i = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; uart_rxd_i = 1'b1;
      req_i = 1'b0; sel_i = 1'b0; we_i = 1'b0; addr_i = '0; w_data_i = '0;
      repeat (3) @(posedge clk); #1;
      chk("rst_ack", {31'b0, ack_o}, 32'd0);
      chk("rst_rdata", r_data_o, 32'd0);
      chk("rst_irq", {31'b0, irq_o}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      bus_read(4'h8, rd, ak); chk("rst_baud", rd, 32'd868); chk("rd_ack", {31'b0, ak}, 32'd1);
      @(posedge clk); #1;
      chk("ack_idle", {31'b0, ack_o}, 32'd0);
      chk("rdata_idle", r_data_o, 32'd0);
      bus_read(4'h4, rd, ak); chk("rst_status", rd, 32'd0);
      bus_read(4'hC, rd, ak); chk("rst_ctrl", rd, 32'd0);

      // Basic byte
      bus_write(4'h8, 32'd16);
      bus_write(4'hC, 32'd1);
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
      bus_read(4'h4, rd, ak); chk("a5_status", rd, 32'h1);
      bus_read(4'h0, rd, ak); chk("a5_data", rd, 32'hA5);
      bus_read(4'h4, rd, ak); chk("a5_status_after", rd, 32'h0);
      bus_read(4'h0, rd, ak); chk("empty_read", rd, 32'h0); chk("empty_ack", {31'b0, ak}, 32'd1);

      // Short glitch on idle line
      uart_rxd_i = 1'b0;
      repeat (5) @(posedge clk); #1;
      uart_rxd_i = 1'b1;
      repeat (40) @(posedge clk); #1;
      bus_read(4'h4, rd, ak); chk("glitch_status", rd, 32'h0);
      send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
      bus_read(4'h0, rd, ak); chk("post_glitch_data", rd, 32'h5A);

      // Overrun
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
      bus_read(4'h4, rd, ak); chk("ovr_status", rd, 32'h7);
      for (int i = 1; i <= 8; i++) begin
         bus_read(4'h0, rd, ak); chk("fifo_data", rd, 32'(i));
      end
      bus_read(4'h4, rd, ak); chk("ovr_drained", rd, 32'h4);
      bus_write(4'h4, 32'h4);
      bus_read(4'h4, rd, ak); chk("ovr_cleared", rd, 32'h0);

      // Frame error and interrupt
      bus_write(4'hC, 32'd3);
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      bus_read(4'h4, rd, ak); chk("ferr_status", rd, 32'h8);
      chk("ferr_irq", {31'b0, irq_o}, 32'd1);
      bus_write(4'h4, 32'h8);
      @(posedge clk); #1;
      chk("ferr_irq_clr", {31'b0, irq_o}, 32'd0);
      bus_read(4'h4, rd, ak); chk("ferr_cleared", rd, 32'h0);

      // Reset in the middle of a frame
      send_frame(8'h11, 1'b1, 1'b0, 1'b0);
      chk("pend_irq", {31'b0, irq_o}, 32'd1);
      v = 8'h55;
      hold_bit(1'b0);
      for (int b = 0; b < 4; b++) hold_bit(v[b]);
      rst_n = 1'b0; #1;
      chk("mid_rst_irq", {31'b0, irq_o}, 32'd0);
      chk("mid_rst_ack", {31'b0, ack_o}, 32'd0);
      chk("mid_rst_rdata", r_data_o, 32'd0);
      uart_rxd_i = 1'b1;
      repeat (3) @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      bus_read(4'h8, rd, ak); chk("mid_rst_baud", rd, 32'd868);
      bus_read(4'h4, rd, ak); chk("mid_rst_status", rd, 32'h0);
      bus_read(4'hC, rd, ak); chk("mid_rst_ctrl", rd, 32'h0);
      bus_write(4'h8, 32'd16);
      bus_write(4'hC, 32'd1);
      send_frame(8'h55, 1'b1, 1'b0, 1'b0);
      bus_read(4'h0, rd, ak); chk("post_rst_data", rd, 32'h55);
      bus_read(4'h4, rd, ak); chk("post_rst_status", rd, 32'h0);

`ifdef UART_RX_PARITY_EN
      // Even parity
      bus_write(4'hC, 32'd5);
      send_frame(8'h07, 1'b1, 1'b1, 1'b0);
      bus_read(4'h4, rd, ak); chk("par_bad_status", rd, 32'h10);
      bus_write(4'h4, 32'h10);
      bus_read(4'h4, rd, ak); chk("par_cleared", rd, 32'h0);
      send_frame(8'h07, 1'b1, 1'b1, 1'b1);
      bus_read(4'h4, rd, ak); chk("par_ok_status", rd, 32'h1);
      bus_read(4'h0, rd, ak); chk("par_ok_data", rd, 32'h07);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
